// File: rtl/sdhci_dat_rx_lanes.sv
`timescale 1ns/1ps
// sdhci_dat_rx_lanes: SD DAT block receiver for 1/4/8 lanes with per-lane CRC16, end-bit check and 32-bit word streaming.
// Define SDHCI_RX_TIMEOUT_EN to enable the start-bit wait timeout (otherwise timeout_i is ignored).
module sdhci_dat_rx_lanes #(
    parameter int MaxLanes       = 8,
    parameter int BlockSizeWidth = 12,
    parameter int TimeoutWidth   = 24
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      sd_clk_en_p_i,
    input  logic                      start_i,
    input  logic [1:0]                bus_width_i,
    input  logic [BlockSizeWidth-1:0] block_size_i,
    input  logic [TimeoutWidth-1:0]   timeout_i,
    input  logic [MaxLanes-1:0]       dat_i,
    output logic [31:0]               word_o,
    output logic                      word_valid_o,
    input  logic                      word_ready_i,
    output logic                      pause_sd_clk_o,
    output logic                      busy_o,
    output logic                      done_o,
    output logic                      crc_error_o,
    output logic                      end_bit_error_o,
    output logic                      timeout_error_o
);
    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_CRC, S_END, S_DRAIN} state_t;

    state_t                    r_state, w_state_nx;
    logic [1:0]                r_lw, w_lw_in;
    logic [BlockSizeWidth-1:0] r_block_size, r_byte_cnt;
    logic [3:0]                r_cnt, w_last_bit;
    logic [7:0]                r_byte, w_byte_in, w_dat, w_mask, w_crc_msb;
    logic [15:0]               r_crc [MaxLanes];
    logic                      r_crc_err, r_end_err;
    logic [31:0]               r_asm, w_asm_next, r_word;
    logic                      r_asm_full, r_valid;
    logic                      r_done, r_crc_err_p, r_end_err_p, r_to_err_p;
    logic                      w_tick, w_pause, w_start_bit, w_byte_done, w_last_byte;
    logic                      w_word_done, w_out_free, w_drained, w_timeout;

    function automatic logic [15:0] crc16_step(input logic [15:0] c, input logic d);
        return {c[14:0], 1'b0} ^ ((c[15] ^ d) ? 16'h1021 : 16'h0000);
    endfunction

    assign w_dat       = 8'(dat_i);
    assign w_lw_in     = (bus_width_i == 2'b10 && MaxLanes >= 8) ? 2'd2 :
                         (bus_width_i == 2'b01 && MaxLanes >= 4) ? 2'd1 : 2'd0;
    assign w_mask      = (r_lw == 2'd2) ? 8'hFF : (r_lw == 2'd1) ? 8'h0F : 8'h01;
    assign w_last_bit  = (r_lw == 2'd2) ? 4'd0 : (r_lw == 2'd1) ? 4'd1 : 4'd7;
    assign w_byte_in   = (r_lw == 2'd2) ? w_dat :
                         (r_lw == 2'd1) ? {r_byte[3:0], w_dat[3:0]} : {r_byte[6:0], w_dat[0]};
    assign w_pause     = r_state == S_DATA && r_asm_full && r_valid && !word_ready_i;
    assign w_tick      = sd_clk_en_p_i && !w_pause;
    assign w_start_bit = (w_dat & w_mask) == 8'h00;
    assign w_byte_done = r_state == S_DATA && w_tick && r_cnt == w_last_bit;
    assign w_last_byte = r_byte_cnt + BlockSizeWidth'(1) == r_block_size;
    assign w_word_done = w_byte_done && (r_byte_cnt[1:0] == 2'd3 || w_last_byte);
    assign w_out_free  = !r_valid || word_ready_i;
    assign w_drained   = r_state == S_DRAIN && !r_valid && !r_asm_full;

    assign word_o          = r_word;
    assign word_valid_o    = r_valid;
    assign pause_sd_clk_o  = w_pause;
    assign busy_o          = r_state != S_IDLE;
    assign done_o          = r_done;
    assign crc_error_o     = r_crc_err_p;
    assign end_bit_error_o = r_end_err_p;
    assign timeout_error_o = r_to_err_p;

`ifdef SDHCI_RX_TIMEOUT_EN
    logic [TimeoutWidth-1:0] r_timeout, r_to_cnt;
    assign w_timeout = r_state == S_WAIT && w_tick && !w_start_bit && r_timeout != '0 &&
                       r_to_cnt + TimeoutWidth'(1) == r_timeout;
    // Count non-start ticks while waiting for the start bit.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_timeout <= '0;
            r_to_cnt  <= '0;
        end else if (r_state == S_IDLE && start_i) begin
            r_timeout <= timeout_i;
            r_to_cnt  <= '0;
        end else if (r_state == S_WAIT && w_tick) begin
            r_to_cnt <= r_to_cnt + TimeoutWidth'(1);
        end
    end
`else
    logic w_unused_timeout;
    assign w_timeout        = 1'b0;
    assign w_unused_timeout = ^timeout_i;
`endif

    // Top bit of every lane CRC, compared against received CRC bits.
    always_comb begin
        w_crc_msb = '0;
        for (int i = 0; i < MaxLanes; i++) w_crc_msb[i] = r_crc[i][15];
    end

    // Merge the completed byte into the assembly word (fresh word once the old one has left).
    always_comb begin
        w_asm_next = r_asm_full ? '0 : r_asm;
        if (w_byte_done) w_asm_next[8*r_byte_cnt[1:0] +: 8] = w_byte_in;
    end

    // FSM state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_state <= S_IDLE;
        else         r_state <= w_state_nx;
    end

    // FSM next-state logic.
    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            S_IDLE:  if (start_i && block_size_i != '0) w_state_nx = S_WAIT;
            S_WAIT:  if (w_tick && w_start_bit) w_state_nx = S_DATA;
                     else if (w_timeout) w_state_nx = S_IDLE;
            S_DATA:  if (w_byte_done && w_last_byte) w_state_nx = S_CRC;
            S_CRC:   if (w_tick && r_cnt == 4'd15) w_state_nx = S_END;
            S_END:   if (w_tick) w_state_nx = S_DRAIN;
            S_DRAIN: if (w_drained) w_state_nx = S_IDLE;
            default: w_state_nx = S_IDLE;
        endcase
    end

    // Block configuration, bit/byte counters and error accumulation.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_lw         <= '0;
            r_block_size <= '0;
            r_byte       <= '0;
            r_cnt        <= '0;
            r_byte_cnt   <= '0;
            r_crc_err    <= 1'b0;
            r_end_err    <= 1'b0;
        end else if (r_state == S_IDLE && start_i) begin
            r_lw         <= w_lw_in;
            r_block_size <= block_size_i;
            r_cnt        <= '0;
            r_byte_cnt   <= '0;
            r_crc_err    <= 1'b0;
            r_end_err    <= 1'b0;
        end else if (w_tick) begin
            if (r_state == S_DATA) begin
                r_byte <= w_byte_in;
                r_cnt  <= w_byte_done ? 4'd0 : r_cnt + 4'd1;
                if (w_byte_done) r_byte_cnt <= r_byte_cnt + BlockSizeWidth'(1);
            end
            if (r_state == S_CRC) begin
                r_cnt     <= r_cnt + 4'd1;
                r_crc_err <= r_crc_err | (|((w_dat ^ w_crc_msb) & w_mask));
            end
            if (r_state == S_END) r_end_err <= |(~w_dat & w_mask);
        end
    end

    // Per-lane CRC16: accumulate over data, then shift out for comparison.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < MaxLanes; i++) r_crc[i] <= '0;
        end else begin
            for (int i = 0; i < MaxLanes; i++) begin
                if (r_state == S_IDLE && start_i) r_crc[i] <= '0;
                else if (r_state == S_DATA && w_tick && w_mask[i]) r_crc[i] <= crc16_step(r_crc[i], w_dat[i]);
                else if (r_state == S_CRC && w_tick) r_crc[i] <= {r_crc[i][14:0], 1'b0};
            end
        end
    end

    // Assembly and output word registers with same-cycle handoff on accept.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_asm      <= '0;
            r_asm_full <= 1'b0;
            r_word     <= '0;
            r_valid    <= 1'b0;
        end else if (r_asm_full && w_out_free) begin
            r_word     <= r_asm;
            r_valid    <= 1'b1;
            r_asm      <= w_asm_next;
            r_asm_full <= w_word_done;
        end else if (w_word_done && w_out_free) begin
            r_word  <= w_asm_next;
            r_valid <= 1'b1;
            r_asm   <= '0;
        end else begin
            if (w_byte_done) r_asm <= w_asm_next;
            if (w_word_done) r_asm_full <= 1'b1;
            if (word_ready_i) r_valid <= 1'b0;
        end
    end

    // One-cycle completion and error pulses.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_done      <= 1'b0;
            r_crc_err_p <= 1'b0;
            r_end_err_p <= 1'b0;
            r_to_err_p  <= 1'b0;
        end else begin
            r_done      <= (r_state == S_IDLE && start_i && block_size_i == '0) || w_drained || w_timeout;
            r_crc_err_p <= w_drained && r_crc_err;
            r_end_err_p <= w_drained && r_end_err;
            r_to_err_p  <= w_timeout;
        end
    end
endmodule

// File: tb/tb_sdhci_dat_rx_lanes.sv
`timescale 1ns/1ps
// tb_sdhci_dat_rx_lanes: directed self-checking bench for the SD DAT block receiver.
module tb_sdhci_dat_rx_lanes;
    logic        clk_i = 1'b0, rst_ni = 1'b0, sd_en = 1'b0, start = 1'b0, ready = 1'b1;
    logic [1:0]  bw = 2'b00;
    logic [11:0] bsize = '0;
    logic [23:0] tmo = '0;
    logic [7:0]  dat = 8'hFF;
    logic [31:0] word_o;
    logic        word_valid_o, pause_o, busy_o, done_o, crc_error_o, end_bit_error_o, timeout_error_o;

    int n_checks = 0, n_fails = 0;
    int done_cnt, crc_seen, end_seen, to_seen, stray, saw_pause, stable_viol;
    logic        prev_hold = 1'b0;
    logic [31:0] prev_word = '0;
    logic [7:0]  blk[$];
    logic [7:0]  tk[$];
    logic [31:0] exp_w[$];
    logic [31:0] got_w[$];

    sdhci_dat_rx_lanes #(.MaxLanes(8), .BlockSizeWidth(12), .TimeoutWidth(24)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .sd_clk_en_p_i(sd_en), .start_i(start),
        .bus_width_i(bw), .block_size_i(bsize), .timeout_i(tmo), .dat_i(dat),
        .word_o(word_o), .word_valid_o(word_valid_o), .word_ready_i(ready),
        .pause_sd_clk_o(pause_o), .busy_o(busy_o), .done_o(done_o),
        .crc_error_o(crc_error_o), .end_bit_error_o(end_bit_error_o), .timeout_error_o(timeout_error_o)
    );

    always #5 clk_i = ~clk_i;

    // Monitor sampled on the falling edge, away from the active edge.
    always @(negedge clk_i) begin
        if (word_valid_o && ready) got_w.push_back(word_o);
        if (done_o) begin
            done_cnt++;
            crc_seen += int'(crc_error_o);
            end_seen += int'(end_bit_error_o);
            to_seen  += int'(timeout_error_o);
        end
        if (!done_o && (crc_error_o || end_bit_error_o || timeout_error_o)) stray++;
        if (pause_o) saw_pause = 1;
        if (prev_hold && word_o !== prev_word) stable_viol++;
        prev_hold = word_valid_o && !ready;
        prev_word = word_o;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    function automatic logic [15:0] crc_step(input logic [15:0] c, input logic d);
        logic [15:0] r;
        r = c << 1;
        if (c[15] ^ d) r = r ^ 16'h1021;
        return r;
    endfunction

    task automatic clr_mon();
        done_cnt = 0; crc_seen = 0; end_seen = 0; to_seen = 0; stray = 0; saw_pause = 0; stable_viol = 0;
        got_w.delete();
    endtask

    task automatic push_tick(input logic [7:0] v, input logic [7:0] m);
        int n;
        n = tk.size();
        tk.push_back((v & m) | (~m & {8{n[0]}}));
    endtask

    // Build the lane stream (idle, start, data, CRC, end) and the expected words from blk.
    task automatic build(input int lanes, input logic [15:0] crc_xor, input logic [7:0] end_zero,
                         input bit use_const, input logic [15:0] const_crc);
        logic [15:0] c [8];
        logic [7:0]  m, v, b;
        m = lanes == 8 ? 8'hFF : lanes == 4 ? 8'h0F : 8'h01;
        tk.delete();
        exp_w.delete();
        for (int l = 0; l < 8; l++) c[l] = '0;
        for (int i = 0; i < 3; i++) push_tick(8'hFF, m);
        push_tick(8'h00, m);
        foreach (blk[j]) begin
            b = blk[j];
            for (int k = 0; k < 8 / lanes; k++) begin
                v = lanes == 8 ? b : lanes == 4 ? (k == 0 ? {4'h0, b[7:4]} : {4'h0, b[3:0]}) : {7'b0, b[7-k]};
                for (int l = 0; l < lanes; l++) c[l] = crc_step(c[l], v[l]);
                push_tick(v, m);
            end
        end
        if (use_const) c[0] = const_crc;
        c[0] = c[0] ^ crc_xor;
        for (int k = 15; k >= 0; k--) begin
            v = '0;
            for (int l = 0; l < lanes; l++) v[l] = c[l][k];
            push_tick(v, m);
        end
        push_tick(~end_zero, m);
        for (int j = 0; j < blk.size(); j += 4) begin
            logic [31:0] w;
            w = '0;
            for (int k = 0; k < 4; k++) if (j + k < blk.size()) w[8*k +: 8] = blk[j+k];
            exp_w.push_back(w);
        end
    endtask

    // One SD clock rising edge; the generator holds off while pause is requested.
    task automatic sd_tick(input logic [7:0] d);
        int n;
        n = 0;
        dat = d;
        #1;
        while (pause_o && n < 200) begin
            @(posedge clk_i);
            #2;
            n++;
        end
        if (n >= 200) begin
            n_checks++; n_fails++;
            $display("FAIL pause_stuck pause_sd_clk_o=%b required release within 200 cycles", pause_o);
        end
        sd_en = 1'b1;
        @(posedge clk_i);
        #1;
        sd_en = 1'b0;
        @(posedge clk_i);
        #1;
    endtask

    task automatic start_block(input logic [1:0] w, input logic [11:0] sz);
        bw = w; bsize = sz; start = 1'b1;
        @(posedge clk_i);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (done_cnt == 0 && n < 400) begin
            @(posedge clk_i);
            #1;
            n++;
        end
        repeat (2) @(posedge clk_i);
        #1;
    endtask

    task automatic run_block(input logic [1:0] w);
        clr_mon();
        start_block(w, 12'(blk.size()));
        foreach (tk[i]) sd_tick(tk[i]);
        wait_done();
    endtask

    task automatic pulse_reset();
        rst_ni = 1'b0;
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        n_checks++;
        if (word_o !== 32'h0) begin n_fails++; $display("FAIL rst_word got %h required 0", word_o); end
        n_checks++;
        if ({word_valid_o, pause_o, busy_o} !== 3'b000) begin
            n_fails++; $display("FAIL rst_ctrl got valid/pause/busy=%b required 000", {word_valid_o, pause_o, busy_o});
        end
        n_checks++;
        if ({done_o, crc_error_o, end_bit_error_o, timeout_error_o} !== 4'b0000) begin
            n_fails++; $display("FAIL rst_status got %b required 0000", {done_o, crc_error_o, end_bit_error_o, timeout_error_o});
        end
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;
        n_checks++;
        if (busy_o !== 1'b0) begin n_fails++; $display("FAIL rst_release_busy got %b required 0", busy_o); end
    endtask

    task automatic test_1lane_ff(input logic [15:0] crc_xor, input int exp_crc_err);
        blk.delete();
        for (int i = 0; i < 512; i++) blk.push_back(8'hFF);
        build(1, crc_xor, 8'h00, 1'b1, 16'h7FA1);
        run_block(2'b00);
        n_checks++;
        if (got_w.size() !== 128) begin n_fails++; $display("FAIL ff_count got %0d required 128", got_w.size()); end
        for (int i = 0; i < 128; i++) begin
            n_checks++;
            if (got_w.size() <= i || got_w[i] !== 32'hFFFFFFFF) begin
                n_fails++; $display("FAIL ff_word%0d got %h required ffffffff", i, got_w.size() > i ? got_w[i] : 32'hx);
            end
        end
        n_checks++;
        if (done_cnt !== 1) begin n_fails++; $display("FAIL ff_done got %0d pulses required 1", done_cnt); end
        n_checks++;
        if (crc_seen !== exp_crc_err) begin n_fails++; $display("FAIL ff_crc_err got %0d required %0d", crc_seen, exp_crc_err); end
        n_checks++;
        if (end_seen !== 0 || stray !== 0) begin n_fails++; $display("FAIL ff_end_err got end=%0d stray=%0d required 0/0", end_seen, stray); end
    endtask

    task automatic test_4lane_end_bit();
        blk = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        build(4, 16'h0000, 8'h04, 1'b0, 16'h0000);
        run_block(2'b01);
        n_checks++;
        if (got_w.size() !== 2) begin n_fails++; $display("FAIL l4_count got %0d required 2", got_w.size()); end
        n_checks++;
        if (got_w.size() < 1 || got_w[0] !== 32'h04030201) begin
            n_fails++; $display("FAIL l4_word0 got %h required 04030201", got_w.size() > 0 ? got_w[0] : 32'hx);
        end
        n_checks++;
        if (got_w.size() < 2 || got_w[1] !== 32'h00000605) begin
            n_fails++; $display("FAIL l4_word1 got %h required 00000605", got_w.size() > 1 ? got_w[1] : 32'hx);
        end
        n_checks++;
        if (done_cnt !== 1 || end_seen !== 1) begin n_fails++; $display("FAIL l4_end_err got done=%0d end=%0d required 1/1", done_cnt, end_seen); end
        n_checks++;
        if (crc_seen !== 0) begin n_fails++; $display("FAIL l4_crc_err got %0d required 0", crc_seen); end
    endtask

    task automatic test_bw3_partial();
        blk = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};
        build(1, 16'h0000, 8'h00, 1'b0, 16'h0000);
        run_block(2'b11);
        n_checks++;
        if (got_w.size() !== 2 || got_w[0] !== 32'hA4A3A2A1 || got_w[1] !== 32'h000000A5) begin
            n_fails++;
            $display("FAIL bw3_words got n=%0d %h %h required 2 a4a3a2a1 000000a5", got_w.size(),
                     got_w.size() > 0 ? got_w[0] : 32'hx, got_w.size() > 1 ? got_w[1] : 32'hx);
        end
        n_checks++;
        if (done_cnt !== 1 || crc_seen !== 0 || end_seen !== 0) begin
            n_fails++; $display("FAIL bw3_status got done=%0d crc=%0d end=%0d required 1/0/0", done_cnt, crc_seen, end_seen);
        end
    endtask

    task automatic test_back_to_back();
        blk.delete();
        for (int i = 0; i < 64; i++) blk.push_back(8'(i * 7 + 3));
        build(8, 16'h0000, 8'h00, 1'b0, 16'h0000);
        clr_mon();
        start_block(2'b10, 12'd64);
        fork
            foreach (tk[i]) sd_tick(tk[i]);
            begin
                repeat (60) @(posedge clk_i);
                #1;
                ready = 1'b0;
                repeat (20) @(posedge clk_i);
                #1;
                ready = 1'b1;
            end
        join
        wait_done();
        n_checks++;
        if (saw_pause !== 1) begin n_fails++; $display("FAIL bp_pause got saw_pause=%0d required 1", saw_pause); end
        n_checks++;
        if (got_w.size() !== 16) begin n_fails++; $display("FAIL bp_count got %0d required 16", got_w.size()); end
        foreach (exp_w[i]) begin
            n_checks++;
            if (got_w.size() <= i || got_w[i] !== exp_w[i]) begin
                n_fails++; $display("FAIL bp_word%0d got %h required %h", i, got_w.size() > i ? got_w[i] : 32'hx, exp_w[i]);
            end
        end
        n_checks++;
        if (stable_viol !== 0) begin n_fails++; $display("FAIL bp_stable got %0d changes while held required 0", stable_viol); end
        n_checks++;
        if (done_cnt !== 1 || crc_seen !== 0 || end_seen !== 0) begin
            n_fails++; $display("FAIL bp_status got done=%0d crc=%0d end=%0d required 1/0/0", done_cnt, crc_seen, end_seen);
        end
    endtask

    task automatic test_zero_size();
        clr_mon();
        start_block(2'b00, 12'd0);
        n_checks++;
        if (done_o !== 1'b1 || busy_o !== 1'b0) begin
            n_fails++; $display("FAIL zero_done got done=%b busy=%b required 1/0", done_o, busy_o);
        end
        @(posedge clk_i);
        #1;
        n_checks++;
        if (done_o !== 1'b0 || crc_seen + end_seen + to_seen !== 0) begin
            n_fails++; $display("FAIL zero_pulse got done=%b errs=%0d required 0/0", done_o, crc_seen + end_seen + to_seen);
        end
    endtask

    task automatic test_timeout();
        clr_mon();
`ifdef SDHCI_RX_TIMEOUT_EN
        tmo = 24'd100;
        start_block(2'b00, 12'd8);
        repeat (99) sd_tick(8'hFF);
        n_checks++;
        if (done_cnt !== 0) begin n_fails++; $display("FAIL to_early got done=%0d after 99 ticks required 0", done_cnt); end
        sd_tick(8'hFF);
        n_checks++;
        if (done_cnt !== 1 || to_seen !== 1 || busy_o !== 1'b0) begin
            n_fails++; $display("FAIL to_fire got done=%0d to=%0d busy=%b required 1/1/0", done_cnt, to_seen, busy_o);
        end
        n_checks++;
        if (got_w.size() !== 0) begin n_fails++; $display("FAIL to_words got %0d required 0", got_w.size()); end
        clr_mon();
        tmo = 24'd0;
        start_block(2'b00, 12'd8);
        repeat (150) sd_tick(8'hFF);
        n_checks++;
        if (done_cnt !== 0 || busy_o !== 1'b1) begin
            n_fails++; $display("FAIL to_zero got done=%0d busy=%b required 0/1", done_cnt, busy_o);
        end
`else
        tmo = 24'd5;
        start_block(2'b00, 12'd8);
        repeat (20) sd_tick(8'hFF);
        n_checks++;
        if (done_cnt !== 0 || to_seen !== 0 || busy_o !== 1'b1) begin
            n_fails++; $display("FAIL to_disabled got done=%0d to=%0d busy=%b required 0/0/1", done_cnt, to_seen, busy_o);
        end
`endif
        tmo = '0;
        pulse_reset();
    endtask

    task automatic test_reset_mid_block();
        blk = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        build(1, 16'h0000, 8'h00, 1'b0, 16'h0000);
        clr_mon();
        start_block(2'b00, 12'd8);
        for (int i = 0; i < 20; i++) sd_tick(tk[i]);
        rst_ni = 1'b0;
        #2;
        n_checks++;
        if ({busy_o, word_valid_o, pause_o, done_o} !== 4'b0000 || word_o !== 32'h0) begin
            n_fails++; $display("FAIL mid_rst_out got busy/valid/pause/done=%b word=%h required 0000 0",
                                {busy_o, word_valid_o, pause_o, done_o}, word_o);
        end
        repeat (2) @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;
        n_checks++;
        if (done_cnt !== 0) begin n_fails++; $display("FAIL mid_rst_done got %0d required 0", done_cnt); end
        blk = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h12, 8'h34, 8'h56, 8'h78};
        build(4, 16'h0000, 8'h00, 1'b0, 16'h0000);
        run_block(2'b01);
        n_checks++;
        if (got_w.size() !== 2 || got_w[0] !== 32'hEFBEADDE || got_w[1] !== 32'h78563412) begin
            n_fails++;
            $display("FAIL mid_rst_words got n=%0d %h %h required 2 efbeadde 78563412", got_w.size(),
                     got_w.size() > 0 ? got_w[0] : 32'hx, got_w.size() > 1 ? got_w[1] : 32'hx);
        end
        n_checks++;
        if (done_cnt !== 1 || crc_seen !== 0 || end_seen !== 0) begin
            n_fails++; $display("FAIL mid_rst_status got done=%0d crc=%0d end=%0d required 1/0/0", done_cnt, crc_seen, end_seen);
        end
    endtask

    initial begin
        clr_mon();
        test_reset();
        test_1lane_ff(16'h0000, 0);
        test_1lane_ff(16'h0001, 1);
        test_4lane_end_bit();
        test_bw3_partial();
        test_back_to_back();
        test_zero_size();
        test_timeout();
        test_reset_mid_block();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
